// File: rtl/wr_tai_time_counter.sv
// White Rabbit local time base: TAI seconds plus cycle/ns sub-second counters, with time set,
// bounded slew adjustment and PPS output. Define WR_PPS_MEAS_EN to add pps_in phase measurement.
module wr_tai_time_counter #(
   parameter int CYC_PER_SEC  = 125_000_000,
   parameter int NS_PER_CYC   = 8,
   parameter int TAI_W        = 40,
   parameter int CYC_W        = 28,
   parameter int ADJ_W        = 16,
   parameter int PPS_HIGH_CYC = 12_500_000
) (
   input  logic                    i_clk_sys,
   input  logic                    i_rst,
   input  logic                    i_set_valid,
   input  logic [TAI_W-1:0]        i_set_tai,
   input  logic [CYC_W-1:0]        i_set_cycles,
   output logic                    o_set_err,
   input  logic                    i_adj_valid,
   input  logic signed [ADJ_W-1:0] i_adj_cycles,
   output logic                    o_adj_ready,
   input  logic                    i_pps_in,
   output logic [TAI_W-1:0]        o_tm_tai,
   output logic [CYC_W-1:0]        o_tm_cycles,
   output logic [31:0]             o_tm_nsec,
   output logic                    o_tm_valid,
   output logic                    o_pps_out,
   output logic                    o_pps_p1,
   output logic signed [CYC_W:0]   o_pps_err,
   output logic                    o_pps_err_valid
);

   localparam logic [CYC_W-1:0] LP_CYC_SEC   = CYC_W'(CYC_PER_SEC);
   localparam logic [CYC_W-1:0] LP_CYC_LAST  = CYC_W'(CYC_PER_SEC - 1);
   localparam logic [CYC_W-1:0] LP_CYC_LAST2 = CYC_W'(CYC_PER_SEC - 2);
   localparam logic [CYC_W-1:0] LP_PPS_HIGH  = CYC_W'(PPS_HIGH_CYC);
   localparam logic [31:0]      LP_NS        = 32'(NS_PER_CYC);
   localparam logic [31:0]      LP_NS2       = 32'(2 * NS_PER_CYC);
   localparam logic [ADJ_W-2:0] LP_REM_MAX   = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_SLEW_FWD, ST_SLEW_BACK} state_t;

   state_t           r_state, w_state_nxt;
   logic [ADJ_W-2:0] r_rem, w_rem_nxt;

   logic [TAI_W-1:0] r_tai, w_tai_nxt;
   logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
   logic [31:0]      r_nsec, w_nsec_nxt;
   logic             r_valid, r_pps_out, r_pps_p1, r_set_err;
   logic             w_wrap;

   logic             w_set_ok, w_set_load, w_set_bad, w_adj_acc;
   logic [ADJ_W-1:0] w_adj_neg;
   logic [ADJ_W-2:0] w_adj_mag;
   logic [31:0]      w_set_nsec;

   assign w_set_ok   = i_set_cycles < LP_CYC_SEC;
   assign w_set_load = i_set_valid & w_set_ok;
   assign w_set_bad  = i_set_valid & ~w_set_ok;
   assign w_set_nsec = 32'(i_set_cycles) * LP_NS;

   // A set in the same cycle always wins; zero-length slews are not accepted.
   assign w_adj_acc = i_adj_valid & (r_state == ST_IDLE) & ~i_set_valid & (i_adj_cycles != '0);

   // Most-negative request has no positive counterpart in ADJ_W-1 bits, so it saturates.
   assign w_adj_neg = ADJ_W'(-i_adj_cycles);
   always_comb begin
      w_adj_mag = i_adj_cycles[ADJ_W-2:0];
      if (i_adj_cycles[ADJ_W-1]) begin
         w_adj_mag = w_adj_neg[ADJ_W-1] ? LP_REM_MAX : w_adj_neg[ADJ_W-2:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      case (r_state)
         ST_IDLE: begin
            if (w_adj_acc) begin
               w_state_nxt = i_adj_cycles[ADJ_W-1] ? ST_SLEW_BACK : ST_SLEW_FWD;
               w_rem_nxt   = w_adj_mag;
            end
         end
         ST_SLEW_FWD, ST_SLEW_BACK: begin
            w_rem_nxt = r_rem - 1'b1;
            if (r_rem <= ADJ_W'(1)) begin
               w_state_nxt = ST_IDLE;
               w_rem_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = '0;
         end
      endcase
      if (w_set_load) begin
         w_state_nxt = ST_IDLE;
         w_rem_nxt   = '0;
      end
   end

   always_comb begin
      w_tai_nxt  = r_tai;
      w_cyc_nxt  = r_cyc;
      w_nsec_nxt = r_nsec;
      w_wrap     = 1'b0;
      if (r_state == ST_SLEW_BACK) begin
         w_cyc_nxt = r_cyc;
      end else if (r_state == ST_SLEW_FWD) begin
         if (r_cyc == LP_CYC_LAST2) begin
            w_cyc_nxt  = '0;
            w_nsec_nxt = '0;
            w_wrap     = 1'b1;
         end else if (r_cyc == LP_CYC_LAST) begin
            w_cyc_nxt  = CYC_W'(1);
            w_nsec_nxt = LP_NS;
            w_wrap     = 1'b1;
         end else begin
            w_cyc_nxt  = r_cyc + CYC_W'(2);
            w_nsec_nxt = r_nsec + LP_NS2;
         end
      end else begin
         if (r_cyc == LP_CYC_LAST) begin
            w_cyc_nxt  = '0;
            w_nsec_nxt = '0;
            w_wrap     = 1'b1;
         end else begin
            w_cyc_nxt  = r_cyc + CYC_W'(1);
            w_nsec_nxt = r_nsec + LP_NS;
         end
      end
      if (w_wrap) w_tai_nxt = r_tai + TAI_W'(1);
      if (w_set_load) begin
         w_tai_nxt  = i_set_tai;
         w_cyc_nxt  = i_set_cycles;
         w_nsec_nxt = w_set_nsec;
         w_wrap     = 1'b0;
      end
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_rem     <= '0;
         r_tai     <= '0;
         r_cyc     <= '0;
         r_nsec    <= '0;
         r_valid   <= 1'b0;
         r_pps_out <= 1'b0;
         r_pps_p1  <= 1'b0;
         r_set_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rem     <= w_rem_nxt;
         r_tai     <= w_tai_nxt;
         r_cyc     <= w_cyc_nxt;
         r_nsec    <= w_nsec_nxt;
         r_valid   <= r_valid | w_set_load;
         r_pps_out <= (r_valid | w_set_load) & (w_cyc_nxt < LP_PPS_HIGH);
         r_pps_p1  <= w_wrap;
         r_set_err <= w_set_bad;
      end
   end

   assign o_tm_tai    = r_tai;
   assign o_tm_cycles = r_cyc;
   assign o_tm_nsec   = r_nsec;
   assign o_tm_valid  = r_valid;
   assign o_pps_out   = r_pps_out;
   assign o_pps_p1    = r_pps_p1;
   assign o_set_err   = r_set_err;
   assign o_adj_ready = (r_state == ST_IDLE);

`ifdef WR_PPS_MEAS_EN
   localparam logic [CYC_W-1:0] LP_CYC_HALF = CYC_W'(CYC_PER_SEC / 2);
   localparam logic [CYC_W:0]   LP_CYC_FULL = (CYC_W+1)'(CYC_PER_SEC);

   logic [2:0]            r_pps_sync;
   logic [1:0][CYC_W-1:0] r_cyc_pipe;
   logic [1:0]            r_vld_pipe;
   logic signed [CYC_W:0] r_pps_err;
   logic                  r_pps_err_valid;
   logic [CYC_W:0]        w_err;

   // Time snapshot travels alongside the synchroniser so the error refers to the sampling edge.
   assign w_err = (r_cyc_pipe[1] < LP_CYC_HALF) ? {1'b0, r_cyc_pipe[1]}
                                                : {1'b0, r_cyc_pipe[1]} - LP_CYC_FULL;

   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         r_pps_sync      <= '0;
         r_cyc_pipe      <= '0;
         r_vld_pipe      <= '0;
         r_pps_err       <= '0;
         r_pps_err_valid <= 1'b0;
      end else begin
         r_pps_sync      <= {r_pps_sync[1:0], i_pps_in};
         r_cyc_pipe      <= {r_cyc_pipe[0], r_cyc};
         r_vld_pipe      <= {r_vld_pipe[0], r_valid};
         r_pps_err_valid <= 1'b0;
         if (r_pps_sync[1] & ~r_pps_sync[2] & r_vld_pipe[1]) begin
            r_pps_err       <= w_err;
            r_pps_err_valid <= 1'b1;
         end
      end
   end

   assign o_pps_err       = r_pps_err;
   assign o_pps_err_valid = r_pps_err_valid;
`else
   logic w_unused_pps_in;
   assign w_unused_pps_in = i_pps_in;
   assign o_pps_err       = '0;
   assign o_pps_err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_wr_tai_time_counter.sv
// Directed bench for wr_tai_time_counter at 100 cycles/s, 10 ns/cycle; the measurement test
// runs only when WR_PPS_MEAS_EN is defined, otherwise the disabled outputs are checked.
module tb_wr_tai_time_counter;

   logic              clk = 1'b0;
   logic              rst, set_valid, adj_valid, pps_in;
   logic [39:0]       set_tai;
   logic [7:0]        set_cycles;
   logic signed [7:0] adj_cycles;
   logic              set_err, adj_ready, tm_valid, pps_out, pps_p1, pps_err_valid;
   logic [39:0]       tm_tai;
   logic [7:0]        tm_cycles;
   logic [31:0]       tm_nsec;
   logic signed [8:0] pps_err;

   int checks = 0;
   int errors = 0;

   wr_tai_time_counter #(
      .CYC_PER_SEC(100), .NS_PER_CYC(10), .TAI_W(40), .CYC_W(8), .ADJ_W(8), .PPS_HIGH_CYC(10)
   ) dut (
      .i_clk_sys(clk), .i_rst(rst), .i_set_valid(set_valid), .i_set_tai(set_tai),
      .i_set_cycles(set_cycles), .o_set_err(set_err), .i_adj_valid(adj_valid),
      .i_adj_cycles(adj_cycles), .o_adj_ready(adj_ready), .i_pps_in(pps_in),
      .o_tm_tai(tm_tai), .o_tm_cycles(tm_cycles), .o_tm_nsec(tm_nsec), .o_tm_valid(tm_valid),
      .o_pps_out(pps_out), .o_pps_p1(pps_p1), .o_pps_err(pps_err),
      .o_pps_err_valid(pps_err_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      int n = 0;
      while (int'(tm_cycles) != c && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (int'(tm_cycles) != c) begin
         errors++;
         $display("FAIL wait_cyc got %0d want %0d", tm_cycles, c);
      end
   endtask

   task automatic do_set(input logic [39:0] t, input logic [7:0] c);
      set_valid = 1'b1; set_tai = t; set_cycles = c;
      tick();
      set_valid = 1'b0;
   endtask

   task automatic test_reset();
      int p1n = 0, ppsn = 0, bad = 0;
      rst = 1'b1;
      repeat (5) tick();
      checks++;
      if ({tm_tai, tm_cycles, tm_nsec} !== '0 || {tm_valid, pps_out, pps_p1, set_err} !== 4'b0 ||
          adj_ready !== 1'b1 || pps_err !== 9'sd0 || pps_err_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state tai=%0d cyc=%0d ns=%0d v=%b pps=%b p1=%b rdy=%b serr=%b",
                  tm_tai, tm_cycles, tm_nsec, tm_valid, pps_out, pps_p1, adj_ready, set_err);
      end
      rst = 1'b0;
      for (int k = 0; k < 250; k++) begin
         tick();
         if (pps_p1) p1n++;
         if (pps_out) ppsn++;
         if (tm_nsec !== 32'(tm_cycles) * 32'd10) bad++;
      end
      checks++;
      if (tm_tai !== 40'd2 || tm_cycles !== 8'd50 || tm_nsec !== 32'd500) begin
         errors++;
         $display("FAIL freerun got tai=%0d cyc=%0d ns=%0d want 2/50/500", tm_tai, tm_cycles, tm_nsec);
      end
      checks++;
      if (p1n != 2 || ppsn != 0 || bad != 0 || tm_valid !== 1'b0) begin
         errors++;
         $display("FAIL freerun_pps p1=%0d(2) pps=%0d(0) nsbad=%0d(0) valid=%b(0)", p1n, ppsn, bad, tm_valid);
      end
   endtask

   task automatic test_set();
      int p1n = 0, ppsn = 0;
      do_set(40'd7, 8'd95);
      checks++;
      if (tm_tai !== 40'd7 || tm_cycles !== 8'd95 || tm_nsec !== 32'd950 || tm_valid !== 1'b1 ||
          pps_p1 !== 1'b0 || pps_out !== 1'b0) begin
         errors++;
         $display("FAIL set_load got tai=%0d cyc=%0d ns=%0d v=%b p1=%b pps=%b want 7/95/950/1/0/0",
                  tm_tai, tm_cycles, tm_nsec, tm_valid, pps_p1, pps_out);
      end
      for (int k = 1; k <= 20; k++) begin
         int ec, et;
         tick();
         ec = (95 + k) % 100;
         et = (95 + k >= 100) ? 8 : 7;
         if (pps_p1) p1n++;
         if (pps_out) ppsn++;
         checks++;
         if (int'(tm_cycles) != ec || tm_tai !== 40'(et) || pps_out !== (ec < 10) ||
             pps_p1 !== (ec == 0) || tm_nsec !== 32'(ec * 10)) begin
            errors++;
            $display("FAIL set_run k=%0d got cyc=%0d tai=%0d pps=%b p1=%b ns=%0d want cyc=%0d tai=%0d",
                     k, tm_cycles, tm_tai, pps_out, pps_p1, tm_nsec, ec, et);
         end
      end
      checks++;
      if (p1n != 1 || ppsn != 10) begin
         errors++;
         $display("FAIL set_pps_counts p1=%0d(1) pps_high=%0d(10)", p1n, ppsn);
      end
   endtask

   // Accepted at c0 (step 1 that cycle) then six +2 steps.
   task automatic slew_fwd6(input int c0, input int t0, input int exp_seq[6]);
      int p1n = 0;
      wait_cyc(c0);
      adj_valid = 1'b1; adj_cycles = 8'sd6;
      tick();
      adj_valid = 1'b0;
      checks++;
      if (int'(tm_cycles) != c0 + 1 || adj_ready !== 1'b0 || tm_tai !== 40'(t0)) begin
         errors++;
         $display("FAIL fwd_accept got cyc=%0d rdy=%b tai=%0d want %0d/0/%0d", tm_cycles, adj_ready, tm_tai, c0 + 1, t0);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         if (pps_p1) p1n++;
         checks++;
         if (int'(tm_cycles) != exp_seq[k] || tm_nsec !== 32'(exp_seq[k] * 10) || adj_ready !== (k == 5)) begin
            errors++;
            $display("FAIL fwd_step k=%0d got cyc=%0d ns=%0d rdy=%b want cyc=%0d", k, tm_cycles, tm_nsec, adj_ready, exp_seq[k]);
         end
      end
      checks++;
      if (p1n != 1 || tm_tai !== 40'(t0 + 1)) begin
         errors++;
         $display("FAIL fwd_wrap p1=%0d(1) tai=%0d(%0d)", p1n, tm_tai, t0 + 1);
      end
   endtask

   task automatic test_slew_fwd();
      slew_fwd6(90, 8, '{93, 95, 97, 99, 1, 3});
      slew_fwd6(89, 9, '{92, 94, 96, 98, 0, 2});
   endtask

   task automatic test_slew_back();
      wait_cyc(20);
      adj_valid = 1'b1; adj_cycles = -8'sd4;
      tick();
      adj_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (tm_cycles !== 8'd21 || adj_ready !== (k == 3)) begin
            errors++;
            $display("FAIL back_hold k=%0d got cyc=%0d rdy=%b want 21", k, tm_cycles, adj_ready);
         end
      end
      tick();
      checks++;
      if (tm_cycles !== 8'd22 || tm_tai !== 40'd10) begin
         errors++;
         $display("FAIL back_resume got cyc=%0d tai=%0d want 22/10", tm_cycles, tm_tai);
      end
   endtask

   task automatic test_set_adj_conflict();
      int n;
      set_valid = 1'b1; set_tai = 40'd3; set_cycles = 8'd50;
      adj_valid = 1'b1; adj_cycles = 8'sd5;
      tick();
      set_valid = 1'b0; adj_valid = 1'b0;
      checks++;
      if (tm_tai !== 40'd3 || tm_cycles !== 8'd50 || tm_nsec !== 32'd500 || adj_ready !== 1'b1) begin
         errors++;
         $display("FAIL set_wins got tai=%0d cyc=%0d ns=%0d rdy=%b", tm_tai, tm_cycles, tm_nsec, adj_ready);
      end
      tick();
      checks++;
      if (tm_cycles !== 8'd51 || adj_ready !== 1'b1) begin
         errors++;
         $display("FAIL adj_dropped got cyc=%0d rdy=%b want 51/1", tm_cycles, adj_ready);
      end
      adj_valid = 1'b1; adj_cycles = 8'sd10;
      tick();
      adj_valid = 1'b0;
      tick();
      do_set(40'd4, 8'd10);
      checks++;
      if (tm_cycles !== 8'd10 || tm_nsec !== 32'd100 || adj_ready !== 1'b1 || pps_out !== 1'b0) begin
         errors++;
         $display("FAIL set_abort got cyc=%0d ns=%0d rdy=%b pps=%b want 10/100/1/0", tm_cycles, tm_nsec, adj_ready, pps_out);
      end
      tick();
      checks++;
      if (tm_cycles !== 8'd11) begin
         errors++;
         $display("FAIL set_abort_step got cyc=%0d want 11", tm_cycles);
      end
      do_set(40'd9, 8'd100);
      checks++;
      if (set_err !== 1'b1 || tm_cycles !== 8'd12 || tm_tai !== 40'd4) begin
         errors++;
         $display("FAIL set_bad got err=%b cyc=%0d tai=%0d want 1/12/4", set_err, tm_cycles, tm_tai);
      end
      tick();
      checks++;
      if (set_err !== 1'b0 || tm_cycles !== 8'd13) begin
         errors++;
         $display("FAIL set_err_pulse got err=%b cyc=%0d want 0/13", set_err, tm_cycles);
      end
      do_set(40'd5, 8'd99);
      tick();
      checks++;
      if (tm_cycles !== 8'd0 || tm_tai !== 40'd6 || pps_p1 !== 1'b1 || pps_out !== 1'b1) begin
         errors++;
         $display("FAIL set99_wrap got cyc=%0d tai=%0d p1=%b pps=%b want 0/6/1/1", tm_cycles, tm_tai, pps_p1, pps_out);
      end
      do_set(40'hFF_FFFF_FFFF, 8'd99);
      tick();
      checks++;
      if (tm_tai !== 40'd0 || pps_p1 !== 1'b1) begin
         errors++;
         $display("FAIL tai_wrap got tai=%0d p1=%b want 0/1", tm_tai, pps_p1);
      end
      do_set(40'd1, 8'd0);
      checks++;
      if (tm_cycles !== 8'd0 || pps_p1 !== 1'b0 || pps_out !== 1'b1) begin
         errors++;
         $display("FAIL set_zero got cyc=%0d p1=%b pps=%b want 0/0/1", tm_cycles, pps_p1, pps_out);
      end
      adj_valid = 1'b1; adj_cycles = -8'sd128;
      tick();
      adj_valid = 1'b0;
      n = 1;
      while (!adj_ready && n < 300) begin
         tick();
         if (!adj_ready) n++;
      end
      checks++;
      if (n != 127 || tm_cycles !== 8'd1 || tm_tai !== 40'd1) begin
         errors++;
         $display("FAIL adj_saturate low=%0d(127) cyc=%0d(1) tai=%0d(1)", n, tm_cycles, tm_tai);
      end
   endtask

`ifdef WR_PPS_MEAS_EN
   task automatic pps_edge_at(input int c, input logic signed [8:0] exp_err);
      wait_cyc(c);
      pps_in = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (pps_err_valid !== (k == 3) || (k == 3 && pps_err !== exp_err)) begin
            errors++;
            $display("FAIL pps_meas c=%0d k=%0d got v=%b err=%0d want err=%0d", c, k, pps_err_valid, pps_err, exp_err);
         end
      end
      pps_in = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_pps_meas();
      int vn = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pps_in = 1'b1;
      repeat (3) tick();
      pps_in = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (pps_err_valid) vn++;
      end
      checks++;
      if (vn != 0) begin
         errors++;
         $display("FAIL pps_unset got %0d strobes want 0", vn);
      end
      do_set(40'd1, 8'd40);
      pps_edge_at(97, -9'sd3);
      pps_edge_at(5, 9'sd5);
      pps_edge_at(50, -9'sd50);
   endtask
`else
   task automatic test_pps_meas();
      int vn = 0;
      for (int k = 0; k < 20; k++) begin
         pps_in = k[2];
         tick();
         if (pps_err_valid || pps_err !== 9'sd0) vn++;
      end
      checks++;
      if (vn != 0) begin
         errors++;
         $display("FAIL pps_disabled got %0d nonzero samples want 0", vn);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; set_valid = 1'b0; adj_valid = 1'b0; pps_in = 1'b0;
      set_tai = '0; set_cycles = '0; adj_cycles = '0;
      test_reset();
      test_set();
      test_slew_fwd();
      test_slew_back();
      test_set_adj_conflict();
      test_pps_meas();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
